// File: rtl/count_monitor_pkg.sv
// Shared types and default parameters for the count_monitor slice.
// Optional macro COUNT_MONITOR_FAIL_STICKY_EN adds the absorbing S_FAIL state.
package count_monitor_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_SYNC_CNT = 2;
  localparam int DEF_WRAP_W   = 8;
  localparam int DEF_ERR_W    = 8;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
`ifdef COUNT_MONITOR_FAIL_STICKY_EN
    ,
    S_FAIL = 2'd3
`endif
  } state_t;

  // Bits needed to hold values 0..sync_cnt, never less than one.
  function automatic int match_width(input int sync_cnt);
    int w;
    w = $clog2(sync_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/count_mon_satcnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module count_mon_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/count_monitor.sv
// Checks that q advances by +1 modulo 2^WIDTH every clock; reports lock, wraps and errors.
// Build option COUNT_MONITOR_FAIL_STICKY_EN makes a loss of lock permanent until rst.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SYNC_CNT = DEF_SYNC_CNT,
  parameter int WRAP_W   = DEF_WRAP_W,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WIDTH-1:0]  last_q
);

  localparam int MATCH_W = match_width(SYNC_CNT);

  state_t             state;
  state_t             next_state;
  logic [MATCH_W-1:0] match;
  logic [WIDTH-1:0]   q_expect;
  logic               good_step;
  logic               wrap_seen;
  logic               match_done;
  logic               locked_next;
  logic               err_next;
  logic               wrap_next;
  logic               match_clr;
  logic               match_inc;

  assign q_expect   = last_q + WIDTH'(1);
  assign good_step  = (q == q_expect);
  assign wrap_seen  = (last_q == '1) && (q == '0);
  assign match_done = (match == MATCH_W'(SYNC_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_INIT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT: next_state = S_ACQ;
      S_ACQ:  if (good_step && match_done) next_state = S_LOCK;
      S_LOCK: if (!good_step) begin
`ifdef COUNT_MONITOR_FAIL_STICKY_EN
        next_state = S_FAIL;
`else
        next_state = S_ACQ;
`endif
      end
`ifdef COUNT_MONITOR_FAIL_STICKY_EN
      S_FAIL: next_state = S_FAIL;
`endif
      default: next_state = S_INIT;
    endcase
  end

  // The match counter only runs while acquiring; every other state holds it at zero.
  always_comb begin
    locked_next = 1'b0;
    err_next    = 1'b0;
    wrap_next   = 1'b0;
    match_clr   = 1'b1;
    match_inc   = 1'b0;
    case (state)
      S_ACQ: begin
        if (good_step && match_done) begin
          locked_next = 1'b1;
        end else if (good_step) begin
          match_clr = 1'b0;
          match_inc = 1'b1;
        end
      end
      S_LOCK: begin
        if (good_step) begin
          locked_next = 1'b1;
          wrap_next   = wrap_seen;
        end else begin
          err_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked     <= 1'b0;
      err        <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      last_q     <= '0;
    end else begin
      locked     <= locked_next;
      err        <= err_next;
      wrap_pulse <= wrap_next;
      last_q     <= q;
      if (wrap_next)
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end

  count_mon_satcnt #(.W(MATCH_W)) u_match (
    .clk   (clk),
    .clr   (rst || match_clr),
    .inc   (match_inc),
    .count (match)
  );

  count_mon_satcnt #(.W(ERR_W)) u_errcnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (err_next),
    .count (err_cnt)
  );

endmodule
